ram_access_ctrl: RTL
====================

Name: ram_access_ctrl

Overview:
- Initiator side of the data RAM port: drives the RAM's data-in, word address and write-enable, and samples its data-out.
- Sits between the CPU load/store path, using a valid/ready request/response handshake, and the level-sensitive, combinational-write RAM.
- Sequences every write as setup/strobe/hold so the write-enable is never high while address or data change.
- One outstanding transaction at a time.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, CPU byte-address width
- DIR_W, 5, RAM word-address width (32 words)
- WR_ACK, 1, 1 = writes return a response beat; 0 = writes complete silently

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  load data (0 for stores)
- resp_err  out  1  access rejected (only with feature)
- ram_Datoin  out  DATA_W  to RAM data-in
- ram_Dir  out  DIR_W  to RAM address
- ram_WE  out  1  to RAM write-enable
- ram_Datoout  in  DATA_W  from RAM data-out

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_Datoin=0, ram_Dir=0, ram_WE=0.
- Word index = req_addr[DIR_W+1:2]. Bits [1:0] and bits above DIR_W+1 are ignored unless the feature is enabled.
- req_ready=1 only in IDLE. A request is accepted on a clock edge where req_valid & req_ready. Address and data are latched at acceptance; later req_* changes are ignored.
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, RESP.
- IDLE -> W_SETUP on accepted store. IDLE -> R_ADDR on accepted load.
- W_SETUP: ram_Dir and ram_Datoin take the latched values; ram_WE=0.
- W_STROBE: ram_WE=1 for exactly one cycle; ram_Dir and ram_Datoin unchanged.
- W_HOLD: ram_WE=0; ram_Dir and ram_Datoin unchanged.
- W_HOLD -> RESP if WR_ACK=1, else -> IDLE.
- R_ADDR: ram_Dir driven, ram_WE=0. ram_Datoout is sampled into resp_rdata at the end of this cycle. R_ADDR -> RESP.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid & resp_ready; then -> IDLE and resp_valid drops.
- resp_rdata is cleared to 0 for store responses.
- Latency, measured from the acceptance edge:
  - load: resp_valid high 2 cycles later
  - store: WE high in the 2nd cycle; resp_valid high in the 4th cycle (WR_ACK=1)
- Back-to-back throughput:
  - load: one per 3 cycles with resp_ready tied high
  - store: one per 5 cycles with WR_ACK=1, one per 4 cycles with WR_ACK=0
- ram_WE is never high in IDLE, R_ADDR or RESP.
- ram_Dir and ram_Datoin hold their last values in IDLE, so no spurious RAM write can occur.
- Reset mid-operation: at the next edge every output returns to its reset value, including ram_WE=0 even during W_STROBE. The in-flight transaction is dropped and no response is produced.
- A request arriving while a response is held in RESP waits (req_ready=0).

Optional Feature:
- Macro: RAM_ACCESS_CHECK_EN.
- Defined:
  - At acceptance, req_addr[1:0]!=0 or any req_addr bit above DIR_W+1 set -> go directly to RESP with resp_err=1 and resp_rdata=0.
  - No RAM cycle occurs and ram_WE stays 0.
  - An error response is produced even for stores when WR_ACK=0.
- Not defined: address check logic is omitted; resp_err is tied 0.

Decomposition:
- Shared package: FSM state enumeration (3-bit encoding), DIR_W/DATA_W defaults, word-index extraction constant (byte offset 2).
- One natural sub-module, ram_access_fsm: state register plus next-state logic. The top level holds the address/data/response registers and the RAM port drive.

Test Plan:
- Store addr 0x0000_0014, data 0xDEAD_BEEF, resp_ready=1 -> ram_Dir=5 from the 1st cycle; ram_WE=1 only in the 2nd cycle; resp_valid in the 4th cycle with resp_rdata=0; RAM word 5 = 0xDEAD_BEEF.
- Load addr 0x14 after that store -> resp_valid 2 cycles after acceptance; resp_rdata=0xDEAD_BEEF; ram_WE stays 0 throughout.
- Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable for all 5 cycles; req_ready=0; a new req_valid is not accepted until the cycle after the response handshake.
- rst asserted during W_STROBE -> at the next edge ram_WE=0, req_ready=1, resp_valid=0; no response is ever issued for the dropped store.
- WR_ACK=0, two back-to-back stores to addresses 0x0 and 0x7C -> no resp_valid; second store accepted 4 cycles after the first; words 0 and 31 written.
- With RAM_ACCESS_CHECK_EN, store to 0x16 and load from 0x80 -> each gives resp_err=1 and resp_rdata=0 one cycle after acceptance; ram_WE never asserted.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and defaults for the data-RAM access controller.
// Optional address checking is enabled with the RAM_ACCESS_CHECK_EN macro.
package ram_access_ctrl_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int DIR_W_DEF  = 5;
   localparam int BYTE_OFS   = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_W_SETUP  = 3'd1,
      ST_W_STROBE = 3'd2,
      ST_W_HOLD   = 3'd3,
      ST_R_ADDR   = 3'd4,
      ST_RESP     = 3'd5
   } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// CPU-side request/response handshake of the data-RAM access controller.
interface ram_access_ctrl_if
   import ram_access_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/ram_access_ctrl_fsm.sv
// Transaction sequencer: state register and next-state logic for the
// setup/strobe/hold write cycle, the single-cycle read and the response hold.
module ram_access_ctrl_fsm
   import ram_access_ctrl_pkg::*;
#(
   parameter bit WR_ACK = 1'b1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   req_valid_i,
   input  logic   req_we_i,
   input  logic   addr_err_i,
   input  logic   resp_ready_i,
   output state_e state_q_o,
   output state_e state_d_o
);

   state_e state_q;
   state_e state_d;

   // Next-state selection; unknown encodings fall back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (addr_err_i) begin
                  state_d = ST_RESP;
               end else if (req_we_i) begin
                  state_d = ST_W_SETUP;
               end else begin
                  state_d = ST_R_ADDR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_W_SETUP:  state_d = ST_W_STROBE;
         ST_W_STROBE: state_d = ST_W_HOLD;
         ST_W_HOLD: begin
            if (WR_ACK) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_R_ADDR:   state_d = ST_RESP;
         ST_RESP: begin
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_q_o = state_q;
   assign state_d_o = state_d;

endmodule

// File: rtl/ram_access_ctrl.sv
// Initiator side of the data-RAM port; every output is a flop.
// Define RAM_ACCESS_CHECK_EN to reject misaligned or out-of-range addresses.
module ram_access_ctrl
   import ram_access_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIR_W  = DIR_W_DEF,
   parameter bit WR_ACK = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   ram_access_ctrl_if.slave  cpu,
   output logic [DATA_W-1:0] ram_Datoin,
   output logic [DIR_W-1:0]  ram_Dir,
   output logic              ram_WE,
   input  logic [DATA_W-1:0] ram_Datoout
);

   state_e            state_q;
   state_e            state_d;
   logic              accept_s;
   logic              addr_err_s;
   logic [DIR_W-1:0]  word_idx_s;

   logic              req_ready_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] ram_datoin_q;
   logic [DIR_W-1:0]  ram_dir_q;
   logic              ram_we_q;

   assign word_idx_s = cpu.req_addr[DIR_W+BYTE_OFS-1:BYTE_OFS];
   assign accept_s   = cpu.req_valid && (state_q == ST_IDLE);

`ifdef RAM_ACCESS_CHECK_EN
   assign addr_err_s = (cpu.req_addr[BYTE_OFS-1:0] != {BYTE_OFS{1'b0}}) ||
                       ((cpu.req_addr >> (DIR_W + BYTE_OFS)) != {ADDR_W{1'b0}});
`else
   logic unused_addr_s;
   assign unused_addr_s = ^{cpu.req_addr[BYTE_OFS-1:0], cpu.req_addr[ADDR_W-1:DIR_W+BYTE_OFS]};
   assign addr_err_s    = 1'b0;
`endif

   ram_access_ctrl_fsm #(
      .WR_ACK (WR_ACK)
   ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (cpu.req_valid),
      .req_we_i     (cpu.req_we),
      .addr_err_i   (addr_err_s),
      .resp_ready_i (cpu.resp_ready),
      .state_q_o    (state_q),
      .state_d_o    (state_d)
   );

   // Output flops follow the upcoming state so WE is only high in W_STROBE;
   // RAM address/data only move at acceptance, never while WE can be high.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= {DATA_W{1'b0}};
         resp_err_q   <= 1'b0;
         ram_datoin_q <= {DATA_W{1'b0}};
         ram_dir_q    <= {DIR_W{1'b0}};
         ram_we_q     <= 1'b0;
      end else begin
         req_ready_q  <= (state_d == ST_IDLE);
         resp_valid_q <= (state_d == ST_RESP);
         ram_we_q     <= (state_d == ST_W_STROBE);
         if (accept_s && !addr_err_s) begin
            ram_dir_q <= word_idx_s;
            if (cpu.req_we) begin
               ram_datoin_q <= cpu.req_wdata;
            end
         end
         // Cleared at acceptance so store and error responses carry zero data.
         if (accept_s) begin
            resp_rdata_q <= {DATA_W{1'b0}};
            resp_err_q   <= addr_err_s;
         end else if (state_q == ST_R_ADDR) begin
            resp_rdata_q <= ram_Datoout;
         end
      end
   end

   assign cpu.req_ready  = req_ready_q;
   assign cpu.resp_valid = resp_valid_q;
   assign cpu.resp_rdata = resp_rdata_q;
   assign cpu.resp_err   = resp_err_q;
   assign ram_Datoin     = ram_datoin_q;
   assign ram_Dir        = ram_dir_q;
   assign ram_WE         = ram_we_q;

endmodule
